ext_obi_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one external OBI slave port among NumMasters external OBI masters on the external crossbar.
- Locks the selected master while the slave withholds grant, so the request stays stable.
- Records the master ID of each granted transaction in an in-order FIFO and routes responses back to the originating master.
- Supports up to MaxOutstanding in-flight transactions.

---
 rtl/ext_obi_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ext_obi_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_obi_rr_arbiter.sv
// ext_obi_rr_arbiter: shares one external OBI slave port among several OBI
// masters using round-robin selection. A master whose request is waiting for
// the slave grant is held locked so that the request stays stable. The ID of
// each granted master is kept in an in-order FIFO so that responses can be
// routed back to the master that issued them.
module ext_obi_rr_arbiter #(
  parameter int unsigned NumMasters     = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned IdxW           = (NumMasters > 1) ? $clog2(NumMasters) : 1,
  parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumMasters-1:0]    master_req_i,
  input  logic [NumMasters-1:0]    master_we_i,
  input  logic [4*NumMasters-1:0]  master_be_i,
  input  logic [32*NumMasters-1:0] master_addr_i,
  input  logic [32*NumMasters-1:0] master_wdata_i,
  output logic [NumMasters-1:0]    master_gnt_o,
  output logic [NumMasters-1:0]    master_rvalid_o,
  output logic [32*NumMasters-1:0] master_rdata_o,
  output logic                     slave_req_o,
  output logic                     slave_we_o,
  output logic [3:0]               slave_be_o,
  output logic [31:0]              slave_addr_o,
  output logic [31:0]              slave_wdata_o,
  input  logic                     slave_gnt_i,
  input  logic                     slave_rvalid_i,
  input  logic [31:0]              slave_rdata_i,
  output logic [CntW-1:0]          outstanding_o,
  output logic                     rsp_err_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  // Next master index, wrapping from the last master back to master 0.
  function automatic logic [IdxW-1:0] nextIdx(input logic [IdxW-1:0] idx);
    if (idx == IdxW'(NumMasters - 1)) begin
      return {IdxW{1'b0}};
    end else begin
      return idx + IdxW'(1'b1);
    end
  endfunction

  // Next FIFO slot, wrapping at the FIFO depth.
  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(MaxOutstanding - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return ptr + PtrW'(1'b1);
    end
  endfunction

  logic [IdxW-1:0] rrPtr_r;
  logic            lock_r;
  logic [IdxW-1:0] lockIdx_r;
  logic [IdxW-1:0] fifoMem_r [MaxOutstanding];
  logic [PtrW-1:0] wrPtr_r;
  logic [PtrW-1:0] rdPtr_r;
  logic [CntW-1:0] count_r;

  logic [IdxW-1:0] candIdx_s;
  logic [IdxW-1:0] freeIdx_s;
  logic            found_s;
  logic [IdxW-1:0] chosen_s;
  logic [IdxW-1:0] head_s;
  logic            full_s;
  logic            empty_s;
  logic            fwd_s;
  logic            push_s;
  logic            pop_s;

  // Round-robin scan: first requesting master at or after rrPtr_r.
  always_comb begin
    candIdx_s = rrPtr_r;
    freeIdx_s = {IdxW{1'b0}};
    found_s   = 1'b0;
    for (int i = 0; i < NumMasters; i++) begin
      if (!found_s && master_req_i[candIdx_s]) begin
        found_s   = 1'b1;
        freeIdx_s = candIdx_s;
      end else begin
        found_s   = found_s;
      end
      candIdx_s = nextIdx(candIdx_s);
    end
  end

  // A locked master keeps the port; otherwise the round-robin winner is used.
  assign chosen_s = lock_r ? lockIdx_r : freeIdx_s;
  assign head_s   = fifoMem_r[rdPtr_r];
  // Fullness uses the registered count, so a same-cycle pop never unblocks.
  assign full_s   = (count_r == CntW'(MaxOutstanding));
  assign empty_s  = (count_r == {CntW{1'b0}});
  assign fwd_s    = rst_ni & ((|master_req_i) | lock_r) & ~full_s;
  assign push_s   = fwd_s & slave_gnt_i;
  assign pop_s    = rst_ni & slave_rvalid_i & ~empty_s;

  assign slave_req_o   = fwd_s;
  assign outstanding_o = count_r;
  assign rsp_err_o     = rst_ni & slave_rvalid_i & empty_s;

  // Request mux toward the slave and grant steering back to the chosen master.
  always_comb begin
    slave_we_o    = 1'b0;
    slave_be_o    = 4'b0000;
    slave_addr_o  = 32'h0000_0000;
    slave_wdata_o = 32'h0000_0000;
    master_gnt_o  = {NumMasters{1'b0}};
    if (fwd_s) begin
      slave_we_o             = master_we_i[chosen_s];
      slave_be_o             = master_be_i[chosen_s*4 +: 4];
      slave_addr_o           = master_addr_i[chosen_s*32 +: 32];
      slave_wdata_o          = master_wdata_i[chosen_s*32 +: 32];
      master_gnt_o[chosen_s] = slave_gnt_i;
    end else begin
      master_gnt_o = {NumMasters{1'b0}};
    end
  end

  // Zero-latency response routing to the master at the FIFO head.
  always_comb begin
    master_rvalid_o = {NumMasters{1'b0}};
    master_rdata_o  = {(32*NumMasters){1'b0}};
    if (pop_s) begin
      master_rvalid_o[head_s]          = 1'b1;
      master_rdata_o[head_s*32 +: 32]  = slave_rdata_i;
    end else begin
      master_rvalid_o = {NumMasters{1'b0}};
    end
  end

  // Arbitration state: round-robin pointer and lock on a stalled request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rrPtr_r   <= {IdxW{1'b0}};
      lock_r    <= 1'b0;
      lockIdx_r <= {IdxW{1'b0}};
    end else if (push_s) begin
      rrPtr_r   <= nextIdx(chosen_s);
      lock_r    <= 1'b0;
    end else if (fwd_s) begin
      lock_r    <= 1'b1;
      lockIdx_r <= chosen_s;
    end
  end

  // Response-routing ID FIFO and its occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifoMem_r[i] <= {IdxW{1'b0}};
      end
      wrPtr_r <= {PtrW{1'b0}};
      rdPtr_r <= {PtrW{1'b0}};
      count_r <= {CntW{1'b0}};
    end else begin
      if (push_s) begin
        fifoMem_r[wrPtr_r] <= chosen_s;
        wrPtr_r            <= nextPtr(wrPtr_r);
      end
      if (pop_s) begin
        rdPtr_r <= nextPtr(rdPtr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1'b1);
        2'b01:   count_r <= count_r - CntW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_obi_rr_arbiter.sv
// Directed testbench for ext_obi_rr_arbiter with two masters and two
// outstanding transactions.
module tb_ext_obi_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [1:0]  req, we, gntO, rvO;
  logic [7:0]  be;
  logic [63:0] addr, wdata, rdO;
  logic        sReq, sWe, sGnt, sRv, rspErr;
  logic [3:0]  sBe;
  logic [31:0] sAddr, sWdata, sRdata;
  logic [1:0]  outst;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ext_obi_rr_arbiter #(.NumMasters(2), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .master_req_i(req), .master_we_i(we), .master_be_i(be),
    .master_addr_i(addr), .master_wdata_i(wdata),
    .master_gnt_o(gntO), .master_rvalid_o(rvO), .master_rdata_o(rdO),
    .slave_req_o(sReq), .slave_we_o(sWe), .slave_be_o(sBe),
    .slave_addr_o(sAddr), .slave_wdata_o(sWdata),
    .slave_gnt_i(sGnt), .slave_rvalid_i(sRv), .slave_rdata_i(sRdata),
    .outstanding_o(outst), .rsp_err_o(rspErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 2'b00; sGnt = 1'b0; sRv = 1'b0; sRdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; we = 2'b00; be = 8'hFF; addr = {32'h2, 32'h1}; wdata = 64'h0;
    req = 2'b11; sGnt = 1'b1; sRv = 1'b1; sRdata = 32'h1234_5678;
    #2;
    vecs++; if (sReq !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", sReq); end
    vecs++; if (gntO !== 2'b00) begin errs++; $display("FAIL rst_gnt: got %b want 00", gntO); end
    vecs++; if (rvO !== 2'b00) begin errs++; $display("FAIL rst_rvalid: got %b want 00", rvO); end
    vecs++; if (rdO !== 64'h0) begin errs++; $display("FAIL rst_rdata: got %h want 0", rdO); end
    vecs++; if (sAddr !== 32'h0) begin errs++; $display("FAIL rst_addr: got %h want 0", sAddr); end
    vecs++; if (rspErr !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", rspErr); end
    vecs++; if (outst !== 2'd0) begin errs++; $display("FAIL rst_outst: got %0d want 0", outst); end
    tick();
    vecs++; if (outst !== 2'd0) begin errs++; $display("FAIL rst_outst_edge: got %0d want 0", outst); end
    idle(); rst_ni = 1'b1;
    #1;
    vecs++; if (sReq !== 1'b0) begin errs++; $display("FAIL rst_idle_req: got %b want 0", sReq); end
  endtask

  task automatic test_single();
    tick();
    addr = {32'h0, 32'h2000_0004}; we = 2'b00; req = 2'b01; sGnt = 1'b1;
    #1;
    vecs++; if (gntO !== 2'b01) begin errs++; $display("FAIL single_gnt: got %b want 01", gntO); end
    vecs++; if (sAddr !== 32'h2000_0004) begin errs++; $display("FAIL single_addr: got %h want 20000004", sAddr); end
    vecs++; if (sWe !== 1'b0) begin errs++; $display("FAIL single_we: got %b want 0", sWe); end
    vecs++; if (outst !== 2'd0) begin errs++; $display("FAIL single_outst0: got %0d want 0", outst); end
    tick();
    req = 2'b00; sGnt = 1'b0; sRv = 1'b1; sRdata = 32'hDEAD_BEEF;
    #1;
    vecs++; if (outst !== 2'd1) begin errs++; $display("FAIL single_outst1: got %0d want 1", outst); end
    vecs++; if (rvO !== 2'b01) begin errs++; $display("FAIL single_rvalid: got %b want 01", rvO); end
    vecs++; if (rdO !== 64'h0000_0000_DEAD_BEEF) begin errs++; $display("FAIL single_rdata: got %h want 00000000deadbeef", rdO); end
    vecs++; if (rspErr !== 1'b0) begin errs++; $display("FAIL single_err: got %b want 0", rspErr); end
    tick();
    idle();
    #1;
    vecs++; if (outst !== 2'd0) begin errs++; $display("FAIL single_outst2: got %0d want 0", outst); end
    vecs++; if (rvO !== 2'b00) begin errs++; $display("FAIL single_rvalid_off: got %b want 00", rvO); end
  endtask

  // rr pointer is 1 on entry (last grant went to master 0).
  task automatic test_contention();
    logic [1:0]  expGnt [4];
    logic [1:0]  expRv [4];
    logic [31:0] rd;
    logic [63:0] expRd;
    expGnt = '{2'b10, 2'b01, 2'b10, 2'b01};
    expRv  = '{2'b00, 2'b10, 2'b01, 2'b10};
    addr = {32'h1100_0000, 32'h1000_0000};
    for (int k = 0; k < 4; k++) begin
      tick();
      rd = 32'hA000_0000 + k;
      req = 2'b11; sGnt = 1'b1; sRv = (k > 0); sRdata = rd;
      #1;
      expRd = (expRv[k] == 2'b01) ? {32'h0, rd} : (expRv[k] == 2'b10) ? {rd, 32'h0} : 64'h0;
      vecs++; if (gntO !== expGnt[k]) begin errs++; $display("FAIL cont_gnt[%0d]: got %b want %b", k, gntO, expGnt[k]); end
      vecs++; if (sAddr !== ((expGnt[k] == 2'b01) ? 32'h1000_0000 : 32'h1100_0000)) begin errs++; $display("FAIL cont_addr[%0d]: got %h", k, sAddr); end
      vecs++; if (rvO !== expRv[k]) begin errs++; $display("FAIL cont_rvalid[%0d]: got %b want %b", k, rvO, expRv[k]); end
      vecs++; if (rdO !== expRd) begin errs++; $display("FAIL cont_rdata[%0d]: got %h want %h", k, rdO, expRd); end
      vecs++; if (outst !== ((k == 0) ? 2'd0 : 2'd1)) begin errs++; $display("FAIL cont_outst[%0d]: got %0d", k, outst); end
    end
    tick();
    req = 2'b00; sGnt = 1'b0; sRv = 1'b1; sRdata = 32'hA000_0004;
    #1;
    vecs++; if (rvO !== 2'b01) begin errs++; $display("FAIL cont_last_rvalid: got %b want 01", rvO); end
    tick();
    idle();
    #1;
    vecs++; if (outst !== 2'd0) begin errs++; $display("FAIL cont_drain: got %0d want 0", outst); end
  endtask

  task automatic test_lock_full();
    // Prelude: one master1 transaction moves the rr pointer to 0.
    tick();
    req = 2'b10; sGnt = 1'b1;
    #1;
    vecs++; if (gntO !== 2'b10) begin errs++; $display("FAIL pre_gnt: got %b want 10", gntO); end
    tick();
    req = 2'b00; sGnt = 1'b0; sRv = 1'b1;
    #1;
    vecs++; if (rvO !== 2'b10) begin errs++; $display("FAIL pre_rvalid: got %b want 10", rvO); end
    tick();
    idle();
    addr = {32'h3100_0000, 32'h3000_0000}; we = 2'b10; be = {4'b0011, 4'b1111};
    wdata = {32'h55AA_55AA, 32'h1111_1111};
    // Master1 stalls for 3 cycles; master0 joins in cycle 2 with higher priority.
    for (int k = 0; k < 3; k++) begin
      tick();
      req = (k == 0) ? 2'b10 : 2'b11; sGnt = 1'b0;
      #1;
      vecs++; if (sReq !== 1'b1) begin errs++; $display("FAIL lock_req[%0d]: got %b want 1", k, sReq); end
      vecs++; if (sAddr !== 32'h3100_0000) begin errs++; $display("FAIL lock_addr[%0d]: got %h want 31000000", k, sAddr); end
      vecs++; if (gntO !== 2'b00) begin errs++; $display("FAIL lock_gnt[%0d]: got %b want 00", k, gntO); end
    end
    vecs++; if ({sWe, sBe, sWdata} !== {1'b1, 4'b0011, 32'h55AA_55AA}) begin errs++; $display("FAIL lock_wdata: got %b %b %h", sWe, sBe, sWdata); end
    tick();
    sGnt = 1'b1;
    #1;
    vecs++; if (gntO !== 2'b10) begin errs++; $display("FAIL lock_release_gnt: got %b want 10", gntO); end
    tick();
    #1;
    vecs++; if (gntO !== 2'b01) begin errs++; $display("FAIL lock_next_gnt: got %b want 01", gntO); end
    vecs++; if (sAddr !== 32'h3000_0000) begin errs++; $display("FAIL lock_next_addr: got %h want 30000000", sAddr); end
    vecs++; if (outst !== 2'd1) begin errs++; $display("FAIL lock_outst: got %0d want 1", outst); end
    // FIFO now holds {1, 0}: full.
    tick();
    #1;
    vecs++; if (outst !== 2'd2) begin errs++; $display("FAIL full_outst: got %0d want 2", outst); end
    vecs++; if (sReq !== 1'b0) begin errs++; $display("FAIL full_req: got %b want 0", sReq); end
    vecs++; if (gntO !== 2'b00) begin errs++; $display("FAIL full_gnt: got %b want 00", gntO); end
    tick();
    sRv = 1'b1; sRdata = 32'hCAFE_0001;
    #1;
    vecs++; if (sReq !== 1'b0) begin errs++; $display("FAIL full_pop_req: got %b want 0", sReq); end
    vecs++; if (rvO !== 2'b10) begin errs++; $display("FAIL full_pop_rvalid: got %b want 10", rvO); end
    vecs++; if (rdO !== {32'hCAFE_0001, 32'h0}) begin errs++; $display("FAIL full_pop_rdata: got %h", rdO); end
    tick();
    sRv = 1'b0;
    #1;
    vecs++; if (outst !== 2'd1) begin errs++; $display("FAIL unfull_outst: got %0d want 1", outst); end
    vecs++; if (sReq !== 1'b1) begin errs++; $display("FAIL unfull_req: got %b want 1", sReq); end
    vecs++; if (gntO !== 2'b10) begin errs++; $display("FAIL unfull_gnt: got %b want 10", gntO); end
    tick();
    req = 2'b00; sGnt = 1'b0; sRv = 1'b1; sRdata = 32'hCAFE_0002;
    #1;
    vecs++; if (rvO !== 2'b01) begin errs++; $display("FAIL order_rv0: got %b want 01", rvO); end
    vecs++; if (rdO !== {32'h0, 32'hCAFE_0002}) begin errs++; $display("FAIL order_rd0: got %h", rdO); end
    tick();
    sRdata = 32'hCAFE_0003;
    #1;
    vecs++; if (rvO !== 2'b10) begin errs++; $display("FAIL order_rv1: got %b want 10", rvO); end
    tick();
    idle();
    #1;
    vecs++; if (outst !== 2'd0) begin errs++; $display("FAIL order_drain: got %0d want 0", outst); end
  endtask

  task automatic test_spurious();
    tick();
    sRv = 1'b1; sRdata = 32'hBAD0_BAD0;
    #1;
    vecs++; if (rspErr !== 1'b1) begin errs++; $display("FAIL spur_err: got %b want 1", rspErr); end
    vecs++; if (rvO !== 2'b00) begin errs++; $display("FAIL spur_rvalid: got %b want 00", rvO); end
    vecs++; if (rdO !== 64'h0) begin errs++; $display("FAIL spur_rdata: got %h want 0", rdO); end
    tick();
    sRv = 1'b0;
    #1;
    vecs++; if (rspErr !== 1'b0) begin errs++; $display("FAIL spur_err_off: got %b want 0", rspErr); end
    vecs++; if (outst !== 2'd0) begin errs++; $display("FAIL spur_outst: got %0d want 0", outst); end
  endtask

  task automatic test_reset_midflight();
    tick();
    req = 2'b11; sGnt = 1'b1;
    tick();
    tick();
    vecs++; if (outst !== 2'd2) begin errs++; $display("FAIL mid_outst: got %0d want 2", outst); end
    rst_ni = 1'b0;
    #1;
    vecs++; if (outst !== 2'd0) begin errs++; $display("FAIL mid_rst_outst: got %0d want 0", outst); end
    vecs++; if ({sReq, gntO} !== 3'b000) begin errs++; $display("FAIL mid_rst_out: got %b want 000", {sReq, gntO}); end
    tick();
    rst_ni = 1'b1; idle();
    #1;
    vecs++; if (outst !== 2'd0) begin errs++; $display("FAIL mid_post_outst: got %0d want 0", outst); end
    tick();
    sRv = 1'b1; sRdata = 32'h0000_0042;
    #1;
    vecs++; if (rspErr !== 1'b1) begin errs++; $display("FAIL mid_late_err: got %b want 1", rspErr); end
    vecs++; if (rvO !== 2'b00) begin errs++; $display("FAIL mid_late_rvalid: got %b want 00", rvO); end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock_full();
    test_spurious();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
